mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 62 ++++++
 rtl/mem_lsu.sv | 132 +++++++++++++
 tb/tb_mem_lsu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the mem_lsu load/store unit.
//   lsu_size_e : access size encoding on req_size (byte / half / word / illegal)
//   ST_*       : FSM state encoding used by mem_lsu
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } lsu_size_e;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RD   = 2'b01;
    localparam logic [1:0] ST_WR   = 2'b10;
    localparam logic [1:0] ST_RESP = 2'b11;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane handling for mem_lsu.
//   i_word     : 32-bit memory word
//   i_addr_lo  : byte offset within the word
//   i_size     : access size
//   i_unsigned : 1 = zero-extend loads, 0 = sign-extend
//   i_wdata    : right-aligned store data (only the low half is ever merged)
//   o_load     : extracted and extended load result
//   o_merged   : i_word with the addressed lane(s) replaced by i_wdata
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  lsu_size_e   i_size,
    input  logic        i_unsigned,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_load   = i_word;
        o_merged = i_word;
        case (i_size)
            SZ_B: begin
                o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                case (i_addr_lo)
                    2'd0: o_merged[7:0]   = i_wdata[7:0];
                    2'd1: o_merged[15:8]  = i_wdata[7:0];
                    2'd2: o_merged[23:16] = i_wdata[7:0];
                    2'd3: o_merged[31:24] = i_wdata[7:0];
                    default: o_merged = i_word;
                endcase
            end
            SZ_H: begin
                o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
                if (i_addr_lo[1]) o_merged[31:16] = i_wdata;
                else              o_merged[15:0]  = i_wdata;
            end
            default: begin
                o_load   = i_word;
                o_merged = i_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit in front of a word-wide memory.
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : request handshake
//   req_we/size/unsigned/addr/wdata : request fields
//   resp_valid/resp_ready      : response handshake
//   resp_rdata/resp_err        : load result / error flag
//   mem_read/mem_write         : one-cycle memory strobes
//   mem_addr/mem_wd/mem_rd     : word address, write data, combinational read data
//
// state | meaning
// IDLE  | ready for a request
// RD    | memory read: load result, or old word for a byte/half store
// WR    | memory write of full or merged word
// RESP  | response held until resp_ready
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    logic [1:0]  r_state;
    logic [1:0]  r_addr_lo;
    lsu_size_e   r_size;
    logic        r_we;
    logic        r_uns;
    logic [31:0] r_wd;
    logic [31:0] r_mem_addr;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    lsu_size_e   w_size;
    logic        w_err;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_size = lsu_size_e'(req_size);
    assign w_err  = (w_size == SZ_X)
                  | ((w_size == SZ_H) & req_addr[0])
                  | ((w_size == SZ_W) & (req_addr[1:0] != 2'b00))
                  | (req_addr >= 32'(MEM_BYTES));

    lsu_lane_align u_align (
        .i_word     (mem_rd),
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_wdata    (r_wd[15:0]),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr_lo    <= 2'b00;
            r_size       <= SZ_B;
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_wd         <= '0;
            r_mem_addr   <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr_lo    <= req_addr[1:0];
                        r_size       <= w_size;
                        r_we         <= req_we;
                        r_uns        <= req_unsigned;
                        r_wd         <= req_wdata;
                        r_mem_addr   <= {req_addr[31:2], 2'b00};
                        r_resp_rdata <= '0;
                        r_resp_err   <= w_err;
                        if (w_err)
                            r_state <= ST_RESP;
                        else if (req_we && (w_size == SZ_W))
                            r_state <= ST_WR;
                        else
                            r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    // A store only reaches RD for read-modify-write.
                    if (r_we) begin
                        r_wd    <= w_merged;
                        r_state <= ST_WR;
                    end else begin
                        r_resp_rdata <= w_load;
                        r_state      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_read   = (r_state == ST_RD);
    assign mem_write  = (r_state == ST_WR);
    assign mem_addr   = r_mem_addr;
    assign mem_wd     = (r_state == ST_WR) ? r_wd : 32'h0;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] tb_mem [0:255];

    int n_checks = 0;
    int n_err    = 0;

    mem_lsu #(.MEM_BYTES(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = tb_mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) tb_mem[mem_addr[9:2]] <= mem_wd;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
        logic [31:0] exp_wd;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction; latency counted in cycles after the accepting edge.
    task automatic xact(input vec_t v);
        int lat, nrd, nwr;
        logic [31:0] rdata, wd;
        logic err, addr_bad;
        lat = 0; nrd = 0; nwr = 0; rdata = 'x; wd = 32'h0; err = 1'bx; addr_bad = 1'b0;
        @(negedge clk);
        req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; wd = mem_wd; end
            if ((mem_read || mem_write) && mem_addr !== {v.addr[31:2], 2'b00}) addr_bad = 1'b1;
            if (resp_valid) begin
                lat = cyc; rdata = resp_rdata; err = resp_err;
                break;
            end
            @(negedge clk);
        end
        check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({v.name, " rdata"},   rdata, v.exp_rdata);
        check({v.name, " err"},     {31'd0, err}, {31'd0, v.exp_err});
        check({v.name, " n_read"},  32'(nrd), 32'(v.exp_nrd));
        check({v.name, " n_write"}, 32'(nwr), 32'(v.exp_nwr));
        check({v.name, " mem_wd"},  wd, v.exp_wd);
        check({v.name, " mem_addr"}, {31'd0, addr_bad}, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;

        //          name          we   size  u     addr        wdata         rdata         err  lat rd wr wd
        vecs[0]  = '{"st_w_10",   1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0, 1, 32'hDEADBEEF};
        vecs[1]  = '{"ld_w_10",   1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0};
        vecs[2]  = '{"st_b_12",   1'b1, 2'b00, 1'b0, 32'h012, 32'h00000055, 32'h00000000, 1'b0, 3, 1, 1, 32'hDE55BEEF};
        vecs[3]  = '{"ld_bs_13",  1'b0, 2'b00, 1'b0, 32'h013, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0};
        vecs[4]  = '{"ld_hu_10",  1'b0, 2'b01, 1'b1, 32'h010, 32'h0,        32'h0000BEEF, 1'b0, 2, 1, 0, 32'h0};
        vecs[5]  = '{"ld_bu_12",  1'b0, 2'b00, 1'b1, 32'h012, 32'h0,        32'h00000055, 1'b0, 2, 1, 0, 32'h0};
        vecs[6]  = '{"ld_hs_12",  1'b0, 2'b01, 1'b0, 32'h012, 32'h0,        32'hFFFFDE55, 1'b0, 2, 1, 0, 32'h0};
        vecs[7]  = '{"ld_bs_10",  1'b0, 2'b00, 1'b0, 32'h010, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 1, 0, 32'h0};
        vecs[8]  = '{"ld_bs_11",  1'b0, 2'b00, 1'b0, 32'h011, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 1, 0, 32'h0};
        vecs[9]  = '{"st_h_10",   1'b1, 2'b01, 1'b0, 32'h010, 32'hABCD1234, 32'h00000000, 1'b0, 3, 1, 1, 32'hDE551234};
        vecs[10] = '{"ld_w_10b",  1'b0, 2'b10, 1'b1, 32'h010, 32'h0,        32'hDE551234, 1'b0, 2, 1, 0, 32'h0};
        vecs[11] = '{"err_h_11",  1'b0, 2'b01, 1'b0, 32'h011, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'h0};
        vecs[12] = '{"err_w_12",  1'b1, 2'b10, 1'b0, 32'h012, 32'h00000001, 32'h00000000, 1'b1, 1, 0, 0, 32'h0};
        vecs[13] = '{"err_sz3",   1'b0, 2'b11, 1'b0, 32'h010, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'h0};
        vecs[14] = '{"err_w_400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'h0};
        vecs[15] = '{"st_b_3ff",  1'b1, 2'b00, 1'b0, 32'h3FF, 32'hFFFFFFA5, 32'h00000000, 1'b0, 3, 1, 1, 32'hA5000000};
        vecs[16] = '{"ld_bs_3ff", 1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 1, 0, 32'h0};
        vecs[17] = '{"ld_hu_3fe", 1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0,        32'h0000A500, 1'b0, 2, 1, 0, 32'h0};
        vecs[18] = '{"err_b_400", 1'b1, 2'b00, 1'b0, 32'h400, 32'h000000AA, 32'h00000000, 1'b1, 1, 0, 0, 32'h0};
        vecs[19] = '{"st_h_16",   1'b1, 2'b01, 1'b0, 32'h016, 32'h00008001, 32'h00000000, 1'b0, 3, 1, 1, 32'h80010000};
        vecs[20] = '{"ld_hs_16",  1'b0, 2'b01, 1'b0, 32'h016, 32'h0,        32'hFFFF8001, 1'b0, 2, 1, 0, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst req_ready",  {31'd0, req_ready},  32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst resp_err",   {31'd0, resp_err},   32'd0);
        check("rst mem_read",   {31'd0, mem_read},   32'd0);
        check("rst mem_write",  {31'd0, mem_write},  32'd0);
        check("rst mem_addr",   mem_addr,   32'h0);
        check("rst mem_wd",     mem_wd,     32'h0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) xact(vecs[i]);

        // Backpressure, with a second request held on the inputs while busy.
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h010; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h3FC;
        for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
        check("bp resp_valid", {31'd0, resp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp hold valid", {31'd0, resp_valid}, 32'd1);
            check("bp hold rdata", resp_rdata, 32'hDE551234);
            check("bp hold err",   {31'd0, resp_err}, 32'd0);
            check("bp req_ready",  {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp release ready", {31'd0, req_ready},  32'd1);
        check("bp release valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp next accepted", {31'd0, mem_read}, 32'd1);
        check("bp next mem_addr", mem_addr, 32'h3FC);
        @(negedge clk);
        check("bp next valid", {31'd0, resp_valid}, 32'd1);
        check("bp next rdata", resp_rdata, 32'hA5000000);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;

        // Reset during the WR cycle of a byte store.
        v = '{"st_w_20", 1'b1, 2'b10, 1'b0, 32'h020, 32'h11223344, 32'h0, 1'b0, 2, 0, 1, 32'h11223344};
        xact(v);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_addr = 32'h021; req_wdata = 32'h99; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw rd phase", {31'd0, mem_read}, 32'd1);
        @(posedge clk);
        #1;
        check("rmw wr phase", {31'd0, mem_write}, 32'd1);
        check("rmw wr data",  mem_wd, 32'h11229944);
        rst_n = 1'b0;
        #1;
        check("mid rst mem_write",  {31'd0, mem_write},  32'd0);
        check("mid rst req_ready",  {31'd0, req_ready},  32'd1);
        check("mid rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("mid rst mem_wd",     mem_wd,   32'h0);
        check("mid rst mem_addr",   mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post rst no write", {31'd0, mem_write},  32'd0);
            check("post rst no resp",  {31'd0, resp_valid}, 32'd0);
        end
        check("post rst mem word", tb_mem[8], 32'h11223344);
        v = '{"ld_w_20", 1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'h11223344, 1'b0, 2, 1, 0, 32'h0};
        xact(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
